lsu: RTL and testbench

Load/store unit. It is the memory-side consumer of the decode control bundle: it takes `mem_access_type`, `mem_access_size` and `mem_sign_ext` together with the ALU-computed address and the rs2 data. It then performs one aligned word transaction on the data-memory bus and returns a sign- or zero-extended load result for register write-back. It sits between execute and the data memory and stalls the core while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 73 +++++++
 rtl/lsu.sv | 141 ++++++++++++++
 tb/tb_lsu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access encodings,
// FSM state encoding and the registered load context.
package lsu_pkg;

    localparam int unsigned CPU_WIDTH             = 32;
    localparam int unsigned MEM_ACCESS_TYPE_WIDTH = 2;
    localparam int unsigned MEM_ACCESS_SIZE_WIDTH = 2;
    localparam int unsigned STRB_WIDTH            = 4;

    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_NONE  = 2'b00;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_READ  = 2'b01;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_WRITE = 2'b10;

    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_NONE = 2'b00;
    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_BYTE = 2'b01;
    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_HALF = 2'b10;
    localparam logic [MEM_ACCESS_SIZE_WIDTH-1:0] MEM_ACCESS_SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

    // Everything needed to extract and extend a load once the response lands.
    typedef struct packed {
        logic [1:0]                       off;
        logic [MEM_ACCESS_SIZE_WIDTH-1:0] size;
        logic                             sign;
    } ld_ctl_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: store lane replication and strobes, load lane
// extraction with sign/zero extension, and misaligned/illegal detection.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CPU_WIDTH
) (
    input  logic [1:0]                       off,
    input  logic [MEM_ACCESS_SIZE_WIDTH-1:0] size,
    input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] access_type,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  ld_ctl_t                          ld_ctl,
    input  logic [DATA_WIDTH-1:0]            rdata,
    output logic [DATA_WIDTH-1:0]            st_wdata_c,
    output logic [STRB_WIDTH-1:0]            st_wstrb_c,
    output logic                             err_c,
    output logic [DATA_WIDTH-1:0]            ld_data_c
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        bad_size;

    // Store lanes; reads leave data and strobes at zero.
    always_comb begin
        st_wdata_c = '0;
        st_wstrb_c = '0;
        if (access_type == MEM_ACCESS_TYPE_WRITE) begin
            case (size)
                MEM_ACCESS_SIZE_BYTE: begin
                    st_wdata_c = {4{wdata[7:0]}};
                    st_wstrb_c = 4'b0001 << off;
                end
                MEM_ACCESS_SIZE_HALF: begin
                    st_wdata_c = {2{wdata[15:0]}};
                    st_wstrb_c = 4'b0011 << off;
                end
                MEM_ACCESS_SIZE_WORD: begin
                    st_wdata_c = wdata;
                    st_wstrb_c = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    // A NONE-type request is never an error; the reserved type always is.
    always_comb begin
        bad_size = 1'b0;
        case (size)
            MEM_ACCESS_SIZE_NONE: bad_size = 1'b1;
            MEM_ACCESS_SIZE_HALF: bad_size = off[0];
            MEM_ACCESS_SIZE_WORD: bad_size = (off != 2'b00);
            default:              bad_size = 1'b0;
        endcase
        err_c = (access_type != MEM_ACCESS_TYPE_NONE) &&
                (bad_size || (access_type == 2'b11));
    end

    assign byte_val = rdata[{ld_ctl.off, 3'b000} +: 8];
    assign half_val = rdata[{ld_ctl.off[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_c = '0;
        case (ld_ctl.size)
            MEM_ACCESS_SIZE_BYTE: ld_data_c = {{(DATA_WIDTH-8){ld_ctl.sign & byte_val[7]}}, byte_val};
            MEM_ACCESS_SIZE_HALF: ld_data_c = {{(DATA_WIDTH-16){ld_ctl.sign & half_val[15]}}, half_val};
            MEM_ACCESS_SIZE_WORD: ld_data_c = rdata;
            default:              ld_data_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access from execute, runs a single aligned
// word transaction on the data bus and returns the extended load result.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = CPU_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             lsu_req_valid,
    output logic                             lsu_req_ready,
    input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] mem_access_type,
    input  logic [MEM_ACCESS_SIZE_WIDTH-1:0] mem_access_size,
    input  logic                             mem_sign_ext,
    input  logic [ADDR_WIDTH-1:0]            lsu_addr,
    input  logic [DATA_WIDTH-1:0]            lsu_wdata,
    output logic                             lsu_done,
    output logic [DATA_WIDTH-1:0]            lsu_rdata,
    output logic                             lsu_err,
    output logic                             bus_req_valid,
    input  logic                             bus_req_ready,
    output logic                             bus_we,
    output logic [ADDR_WIDTH-1:0]            bus_addr,
    output logic [DATA_WIDTH-1:0]            bus_wdata,
    output logic [STRB_WIDTH-1:0]            bus_wstrb,
    input  logic                             bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            bus_rdata
);

    lsu_state_e state_q, state_d;
    ld_ctl_t    ld_ctl_q, ld_ctl_d;

    logic                  accept;
    logic                  align_err_c;
    logic [DATA_WIDTH-1:0] st_wdata_c;
    logic [STRB_WIDTH-1:0] st_wstrb_c;
    logic [DATA_WIDTH-1:0] ld_data_c;

    logic                  done_d, err_d, bus_req_valid_d, bus_we_d;
    logic [DATA_WIDTH-1:0] rdata_d, bus_wdata_d;
    logic [ADDR_WIDTH-1:0] bus_addr_d;
    logic [STRB_WIDTH-1:0] bus_wstrb_d;

    assign lsu_req_ready = (state_q == LSU_IDLE);
    assign accept        = lsu_req_valid && lsu_req_ready &&
                           (mem_access_type != MEM_ACCESS_TYPE_NONE);

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .off         (lsu_addr[1:0]),
        .size        (mem_access_size),
        .access_type (mem_access_type),
        .wdata       (lsu_wdata),
        .ld_ctl      (ld_ctl_q),
        .rdata       (bus_rdata),
        .st_wdata_c  (st_wdata_c),
        .st_wstrb_c  (st_wstrb_c),
        .err_c       (align_err_c),
        .ld_data_c   (ld_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LSU_IDLE;
            ld_ctl_q      <= '0;
            lsu_done      <= 1'b0;
            lsu_err       <= 1'b0;
            lsu_rdata     <= '0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_wstrb     <= '0;
        end else begin
            state_q       <= state_d;
            ld_ctl_q      <= ld_ctl_d;
            lsu_done      <= done_d;
            lsu_err       <= err_d;
            lsu_rdata     <= rdata_d;
            bus_req_valid <= bus_req_valid_d;
            bus_we        <= bus_we_d;
            bus_addr      <= bus_addr_d;
            bus_wdata     <= bus_wdata_d;
            bus_wstrb     <= bus_wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (accept && !align_err_c) state_d = LSU_REQ;
            LSU_REQ:  if (bus_req_ready)          state_d = LSU_WAIT;
            LSU_WAIT: if (bus_rsp_valid)          state_d = LSU_DONE;
            LSU_DONE:                             state_d = LSU_IDLE;
            default:                              state_d = LSU_IDLE;
        endcase
    end

    // Next values of the registered outputs; bus fields hold until the next accept.
    always_comb begin
        done_d          = 1'b0;
        err_d           = 1'b0;
        rdata_d         = lsu_rdata;
        bus_req_valid_d = bus_req_valid;
        bus_we_d        = bus_we;
        bus_addr_d      = bus_addr;
        bus_wdata_d     = bus_wdata;
        bus_wstrb_d     = bus_wstrb;
        ld_ctl_d        = ld_ctl_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    if (align_err_c) begin
                        err_d = 1'b1;
                    end else begin
                        bus_req_valid_d = 1'b1;
                        bus_we_d        = (mem_access_type == MEM_ACCESS_TYPE_WRITE);
                        bus_addr_d      = {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_wdata_d     = st_wdata_c;
                        bus_wstrb_d     = st_wstrb_c;
                        ld_ctl_d        = '{off: lsu_addr[1:0], size: mem_access_size,
                                            sign: mem_sign_ext};
                    end
                end
            end
            LSU_REQ: begin
                if (bus_req_ready) bus_req_valid_d = 1'b0;
            end
            LSU_WAIT: begin
                if (bus_rsp_valid) begin
                    done_d  = 1'b1;
                    rdata_d = bus_we ? '0 : ld_data_c;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases from the feature list plus
// randomized accesses checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [1:0]  mem_access_type;
    logic [1:0]  mem_access_size;
    logic        mem_sign_ext;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rdata = 32'h0;

    localparam logic [1:0] T_NONE = 2'b00, T_READ = 2'b01, T_WRITE = 2'b10;
    localparam logic [1:0] S_NONE = 2'b00, S_BYTE = 2'b01, S_HALF = 2'b10, S_WORD = 2'b11;

    always #5 clk = ~clk;

    lsu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsu_req_valid   (lsu_req_valid),
        .lsu_req_ready   (lsu_req_ready),
        .mem_access_type (mem_access_type),
        .mem_access_size (mem_access_size),
        .mem_sign_ext    (mem_sign_ext),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_done        (lsu_done),
        .lsu_rdata       (lsu_rdata),
        .lsu_err         (lsu_err),
        .bus_req_valid   (bus_req_valid),
        .bus_req_ready   (bus_req_ready),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_rsp_valid   (bus_rsp_valid),
        .bus_rdata       (bus_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic ref_misaligned(input logic [1:0] t, input logic [1:0] s, input logic [31:0] a);
        int nbytes;
        if (t == T_NONE) return 1'b0;
        if (t == 2'b11 || s == S_NONE) return 1'b1;
        nbytes = 1 << (int'(s) - 1);
        return (int'(a[1:0]) % nbytes) != 0;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] t, input logic [1:0] s, input logic [31:0] wd);
        if (t != T_WRITE) return 32'h0;
        case (s)
            S_BYTE:  return (wd & 32'h0000_00FF) * 32'h0101_0101;
            S_HALF:  return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [1:0] t, input logic [1:0] s, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (t != T_WRITE) return 4'h0;
        case (s)
            S_BYTE:  return 4'(1 << off);
            S_HALF:  return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] s, input logic sx, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int off;
        off = int'(a[1:0]);
        case (s)
            S_BYTE: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            S_HALF: begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_req_valid   = 1'b0;
        mem_access_type = T_NONE;
        mem_access_size = S_NONE;
        mem_sign_ext    = 1'b0;
        lsu_addr        = 32'h0;
        lsu_wdata       = 32'h0;
        bus_req_ready   = 1'b0;
        bus_rsp_valid   = 1'b0;
        bus_rdata       = 32'h0;
    endtask

    // One complete access: request, optional backpressure with a stray
    // response, optional response delay, then done/rdata checks.
    task automatic run_op(input string name, input logic [1:0] t, input logic [1:0] s, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int req_wait, input int rsp_wait);
        logic [31:0] ew, ea;
        logic [3:0]  es;
        logic        mis;
        mis = ref_misaligned(t, s, a);
        ew  = ref_wdata(t, s, wd);
        es  = ref_wstrb(t, s, a);
        ea  = a & 32'hFFFF_FFFC;
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL %s ready_before got=%b exp=1", name, lsu_req_ready); end
        lsu_req_valid = 1'b1; mem_access_type = t; mem_access_size = s;
        mem_sign_ext = sx; lsu_addr = a; lsu_wdata = wd;
        step();
        lsu_req_valid = 1'b0; mem_access_type = T_NONE;
        if (t == T_NONE) begin
            checks++; if (bus_req_valid !== 1'b0 || lsu_err !== 1'b0 || lsu_req_ready !== 1'b1) begin
                failures++; $display("FAIL %s none_ignored got valid=%b err=%b ready=%b exp 0/0/1", name, bus_req_valid, lsu_err, lsu_req_ready); end
        end else if (mis) begin
            checks++; if (lsu_err !== 1'b1) begin failures++; $display("FAIL %s err_pulse got=%b exp=1", name, lsu_err); end
            checks++; if (bus_req_valid !== 1'b0 || lsu_req_ready !== 1'b1) begin
                failures++; $display("FAIL %s err_nobus got valid=%b ready=%b exp 0/1", name, bus_req_valid, lsu_req_ready); end
            step();
            checks++; if (lsu_err !== 1'b0 || bus_req_valid !== 1'b0) begin
                failures++; $display("FAIL %s err_one_cycle got err=%b valid=%b exp 0/0", name, lsu_err, bus_req_valid); end
            checks++; if (lsu_rdata !== exp_rdata) begin failures++; $display("FAIL %s err_rdata_hold got=%h exp=%h", name, lsu_rdata, exp_rdata); end
        end else begin
            checks++; if (bus_req_valid !== 1'b1 || lsu_req_ready !== 1'b0) begin
                failures++; $display("FAIL %s req_valid got valid=%b ready=%b exp 1/0", name, bus_req_valid, lsu_req_ready); end
            checks++; if (bus_addr !== ea || bus_we !== (t == T_WRITE) || bus_wdata !== ew || bus_wstrb !== es) begin
                failures++; $display("FAIL %s req_fields got addr=%h we=%b wd=%h st=%b exp addr=%h we=%b wd=%h st=%b",
                    name, bus_addr, bus_we, bus_wdata, bus_wstrb, ea, t == T_WRITE, ew, es); end
            for (int i = 0; i < req_wait; i++) begin
                bus_rsp_valid = (i == 0);
                step();
                bus_rsp_valid = 1'b0;
                checks++; if (bus_req_valid !== 1'b1 || bus_addr !== ea || bus_wdata !== ew || bus_wstrb !== es || lsu_done !== 1'b0) begin
                    failures++; $display("FAIL %s req_stable cyc=%0d got valid=%b addr=%h wd=%h st=%b done=%b", name, i, bus_req_valid, bus_addr, bus_wdata, bus_wstrb, lsu_done); end
            end
            bus_req_ready = 1'b1;
            step();
            bus_req_ready = 1'b0;
            checks++; if (bus_req_valid !== 1'b0) begin failures++; $display("FAIL %s req_drop got=%b exp=0", name, bus_req_valid); end
            for (int i = 0; i < rsp_wait; i++) begin
                step();
                checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL %s early_done cyc=%0d got=%b exp=0", name, i, lsu_done); end
            end
            bus_rsp_valid = 1'b1; bus_rdata = rd;
            step();
            bus_rsp_valid = 1'b0; bus_rdata = $urandom;
            exp_rdata = (t == T_READ) ? ref_load(s, sx, a, rd) : 32'h0;
            checks++; if (lsu_done !== 1'b1) begin failures++; $display("FAIL %s done got=%b exp=1", name, lsu_done); end
            checks++; if (lsu_rdata !== exp_rdata) begin failures++; $display("FAIL %s rdata got=%h exp=%h", name, lsu_rdata, exp_rdata); end
            step();
            checks++; if (lsu_done !== 1'b0 || lsu_req_ready !== 1'b1 || lsu_rdata !== exp_rdata) begin
                failures++; $display("FAIL %s after_done got done=%b ready=%b rdata=%h exp 0/1/%h", name, lsu_done, lsu_req_ready, lsu_rdata, exp_rdata); end
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++; if (lsu_req_ready !== 1'b1 || lsu_done !== 1'b0 || lsu_err !== 1'b0 || lsu_rdata !== 32'h0) begin
            failures++; $display("FAIL %s lsu_outs got ready=%b done=%b err=%b rdata=%h exp 1/0/0/0", name, lsu_req_ready, lsu_done, lsu_err, lsu_rdata); end
        checks++; if (bus_req_valid !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
            failures++; $display("FAIL %s bus_outs got v=%b we=%b a=%h wd=%h st=%b exp all 0", name, bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check_reset_values("reset_async");
        repeat (3) step();
        check_reset_values("reset_held");
        rst_n = 1'b1;
        step();
        check_reset_values("reset_released");
    endtask

    task automatic test_store_lanes();
        run_op("sb_lanes", T_WRITE, S_BYTE, 1'b0, 32'h0000_1003, 32'h1234_5678, 32'h0, 0, 0);
        run_op("sh_lo",    T_WRITE, S_HALF, 1'b0, 32'h0000_1000, 32'hAAAA_BEEF, 32'h0, 0, 1);
        run_op("sh_hi",    T_WRITE, S_HALF, 1'b0, 32'h0000_1002, 32'h5555_C0DE, 32'h0, 1, 0);
        run_op("sb_off1",  T_WRITE, S_BYTE, 1'b0, 32'h0000_1001, 32'h0000_00A5, 32'h0, 0, 0);
    endtask

    task automatic test_loads();
        run_op("lb",  T_READ, S_BYTE, 1'b1, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0);
        run_op("lbu", T_READ, S_BYTE, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 0);
        run_op("lh",  T_READ, S_HALF, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0);
        run_op("lhu", T_READ, S_HALF, 1'b0, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0);
        run_op("lw",  T_READ, S_WORD, 1'b0, 32'h0000_2000, 32'h0, 32'hBEEF_1234, 0, 0);
        run_op("sw_clears_rdata", T_WRITE, S_WORD, 1'b0, 32'h0000_2000, 32'h0102_0304, 32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_misaligned();
        run_op("lb_keep", T_READ, S_BYTE, 1'b1, 32'h0000_2003, 32'h0, 32'h8000_0000, 0, 0);
        run_op("lw_mis",  T_READ,  S_WORD, 1'b0, 32'h0000_2006, 32'h0, 32'h0, 0, 0);
        run_op("sh_mis",  T_WRITE, S_HALF, 1'b0, 32'h0000_3001, 32'h1234_5678, 32'h0, 0, 0);
        run_op("size_none", T_READ, S_NONE, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
        run_op("type_none", T_NONE, S_WORD, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_op("sw_bp", T_WRITE, S_WORD, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 5, 3);
    endtask

    task automatic test_reset_mid();
        // Reset while waiting for the response.
        lsu_req_valid = 1'b1; mem_access_type = T_READ; mem_access_size = S_WORD; lsu_addr = 32'h0000_5004;
        step();
        lsu_req_valid = 1'b0; mem_access_type = T_NONE;
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("reset_in_wait");
        step();
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_rsp_valid = 1'b0;
        checks++; if (lsu_done !== 1'b0 || lsu_rdata !== 32'h0) begin
            failures++; $display("FAIL late_rsp got done=%b rdata=%h exp 0/0", lsu_done, lsu_rdata); end
        step();
        checks++; if (lsu_done !== 1'b0) begin failures++; $display("FAIL late_rsp2 got done=%b exp=0", lsu_done); end
        // Reset while the bus request is pending.
        lsu_req_valid = 1'b1; mem_access_type = T_WRITE; mem_access_size = S_BYTE; lsu_addr = 32'h0000_6002; lsu_wdata = 32'h77;
        step();
        lsu_req_valid = 1'b0; mem_access_type = T_NONE;
        checks++; if (bus_req_valid !== 1'b1) begin failures++; $display("FAIL req_before_rst got=%b exp=1", bus_req_valid); end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("reset_in_req");
        step();
        rst_n = 1'b1;
        step();
        exp_rdata = 32'h0;
    endtask

    task automatic test_random();
        logic [1:0]  t, s;
        logic        sx;
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 9));
            t  = (r == 0) ? T_NONE : (r < 5) ? T_READ : T_WRITE;
            s  = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            a  = $urandom;
            run_op("rand", t, s, sx, a, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_lanes();
        test_loads();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
